bfxp_bitreader: RTL

BFXP_BITREADER -- requirements
Module: bfxp_bitreader

---
 rtl/bfxp_pkg.sv | 15 +
 rtl/bfxp_mask.sv | 14 +
 rtl/bfxp_bitreader.sv | 99 +++++++++
 3 files changed

// File: rtl/bfxp_pkg.sv
// Shared widths and helpers for the bit-field extract/deposit blocks.
// Count width covers 0..BUFW inclusive.
package bfxp_pkg;

    localparam int XLEN = 32;
    localparam int BUFW = 64;
    localparam int CNTW = 7;
    localparam int LENW = 5;

    // Field length fields are encoded as length-1, so 0..31 maps to 1..32 bits.
    function automatic logic [CNTW-1:0] field_bits(input logic [LENW-1:0] len_m1);
        return {{(CNTW-LENW){1'b0}}, len_m1} + CNTW'(1);
    endfunction

endpackage

// File: rtl/bfxp_mask.sv
// Low-order mask generator: len_m1 = n-1 gives a mask with the n lowest bits set.
// Purely combinational so it can be shared with the deposit path.
module bfxp_mask
    import bfxp_pkg::*;
(
    input  logic [LENW-1:0] len_m1,
    output logic [XLEN-1:0] mask
);

    always_comb begin
        mask = {XLEN{1'b1}} >> (LENW'(XLEN - 1) - len_m1);
    end

endmodule

// File: rtl/bfxp_bitreader.sv
// Bit-stream reader: 32-bit words are appended to an LSB-aligned 64-bit buffer
// and fields of 1..32 bits are extracted from the oldest end, one per request.
module bfxp_bitreader
    import bfxp_pkg::*;
(
    input  logic            clock,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [LENW-1:0] req_len,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data
);

    logic [BUFW-1:0] bits_p0;
    logic [CNTW-1:0] cnt_p0;
    logic            vld_p1;
    logic [XLEN-1:0] data_p1;

    logic [CNTW-1:0] take;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] field;
    logic            in_fire;
    logic            req_fire;
    logic [BUFW-1:0] bits_shf;
    logic [CNTW-1:0] cnt_shf;
    logic [BUFW-1:0] bits_nxt;
    logic [CNTW-1:0] cnt_nxt;

    bfxp_mask u_mask (
        .len_m1 (req_len),
        .mask   (mask)
    );

    always_comb begin
        take      = field_bits(req_len);
        in_ready  = (cnt_p0 <= CNTW'(XLEN)) && !flush;
        req_ready = (cnt_p0 >= take) && (!vld_p1 || out_ready) && !flush;
        in_fire   = in_valid && in_ready;
        req_fire  = req_valid && req_ready;
        field     = bits_p0[XLEN-1:0] & mask;
    end

    // Consume first, then append the new word right above the surviving bits;
    // in_ready guarantees the append offset never exceeds 32.
    always_comb begin
        bits_shf = bits_p0;
        cnt_shf  = cnt_p0;
        if (req_fire) begin
            bits_shf = bits_p0 >> take;
            cnt_shf  = cnt_p0 - take;
        end
        bits_nxt = bits_shf;
        cnt_nxt  = cnt_shf;
        if (in_fire) begin
            bits_nxt = bits_shf | (BUFW'(in_data) << cnt_shf);
            cnt_nxt  = cnt_shf + CNTW'(XLEN);
        end
    end

    // Stage p0: bit buffer and fill count
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bits_p0 <= '0;
            cnt_p0  <= '0;
        end else if (flush) begin
            bits_p0 <= '0;
            cnt_p0  <= '0;
        end else begin
            bits_p0 <= bits_nxt;
            cnt_p0  <= cnt_nxt;
        end
    end

    // Stage p1: extracted field slot, held until the consumer takes it
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (req_fire) begin
            vld_p1  <= 1'b1;
            data_p1 <= field;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;

endmodule
